// File: rtl/mem_responder.sv
// ============================================================================
//  Module      : mem_responder
//  Description : Multi-cycle word-memory responder. It accepts one read or
//                write request at a time. After a fixed LATENCY, it completes
//                the request and pulses mem_ready, with mem_err on faults.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_flag,
    input  logic              mem_write_flag,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              busy
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [C_CW-1:0]     cnt_q;
    logic [C_AW-1:0]     idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_q;
    logic                wr_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ready_q;
    logic                err_out_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                req_d;
    logic                enter_done_d;
    logic [C_AW-1:0]     idx_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                rd_d;
    logic                wr_d;
    logic                err_d;
    logic                mem_we_d;

    // When LATENCY is 1, the access completes on the sampling edge. In that
    // case the live inputs are used directly. Otherwise, the values latched
    // in IDLE are used.
    always_comb begin
        req_d        = mem_read_flag | mem_write_flag;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        err_d        = err_q;
        enter_done_d = 1'b0;
        if (state_q == S_IDLE) begin
            idx_d        = addr[C_AW+1:2];
            wdata_d      = wdata;
            rd_d         = mem_read_flag;
            wr_d         = mem_write_flag;
            err_d        = (addr[1:0] != 2'b00) | (mem_read_flag & mem_write_flag);
            enter_done_d = req_d & (LATENCY == 1);
        end else if (state_q == S_WAIT) begin
            enter_done_d = (cnt_q == C_CW'(1));
        end
        // While reset is held, the completing edge must not commit the write.
        mem_we_d = enter_done_d & wr_d & ~err_d & ~rst;
    end

    // Storage array: no reset, so contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    // Control FSM with registered completion, error and read-data outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            ready_q   <= 1'b0;
            err_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_d) begin
                        idx_q   <= idx_d;
                        wdata_q <= wdata_d;
                        rd_q    <= rd_d;
                        wr_q    <= wr_d;
                        err_q   <= err_d;
                        cnt_q   <= C_CW'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - C_CW'(1);
                    if (cnt_q == C_CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (enter_done_d) begin
                ready_q   <= 1'b1;
                err_out_q <= err_d;
                if (err_d) begin
                    rdata_q <= '0;
                end else if (rd_d) begin
                    rdata_q <= mem_q[idx_d];
                end
            end
        end
    end

    assign rdata     = rdata_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_out_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
